// File: rtl/jtag_bitbang_seq_if.sv
// Command/response bundle for the JTAG bit-bang sequencer.
// The master issues commands and consumes responses; the slave is the sequencer.
interface jtag_bitbang_seq_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [5:0]  cmd_len_i;
    logic [31:0] cmd_tms_i;
    logic [31:0] cmd_tdi_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_tdo_o;
    logic        rsp_err_o;

    modport master (
        output cmd_valid_i,
        output cmd_op_i,
        output cmd_len_i,
        output cmd_tms_i,
        output cmd_tdi_i,
        input  cmd_ready_o,
        input  rsp_valid_o,
        output rsp_ready_i,
        input  rsp_tdo_o,
        input  rsp_err_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_op_i,
        input  cmd_len_i,
        input  cmd_tms_i,
        input  cmd_tdi_i,
        output cmd_ready_o,
        output rsp_valid_o,
        input  rsp_ready_i,
        output rsp_tdo_o,
        output rsp_err_o
    );
endinterface

// File: rtl/jtag_bitbang_seq.sv
// Command-driven JTAG pin sequencer: shifts TMS/TDI vectors out on a
// divided TCK, captures TDO per rising edge, and can pulse TRSTn.
module jtag_bitbang_seq #(
    parameter int TCK_DIV   = 2,
    parameter int TRST_TCKS = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    jtag_bitbang_seq_if.slave  bus,
    output logic               busy_o,
    output logic               jtag_tck_o,
    output logic               jtag_tms_o,
    output logic               jtag_tdi_o,
    output logic               jtag_trst_n_o,
    input  logic               jtag_tdo_i
);

    localparam int PW       = $clog2(TCK_DIV) + 1;
    localparam int TRST_CYC = 2 * TCK_DIV * TRST_TCKS;
    localparam int TW       = $clog2(TRST_CYC + 1);

    localparam logic [PW-1:0] PH_LAST = PW'(TCK_DIV - 1);
    localparam logic [TW-1:0] TC_LAST = TW'(TRST_CYC - 1);

    localparam logic [1:0] OP_BITS = 2'd0;
    localparam logic [1:0] OP_TRST = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_TRST,
        S_DONE,
        S_RESP
    } state_e;

    state_e        state_q,   state_d;
    logic [PW-1:0] ph_q,      ph_d;
    logic [TW-1:0] tc_q,      tc_d;
    logic [4:0]    idx_q,     idx_d;
    logic [5:0]    len_q,     len_d;
    logic [31:0]   tms_vec_q, tms_vec_d;
    logic [31:0]   tdi_vec_q, tdi_vec_d;
    logic [31:0]   tdo_q,     tdo_d;
    logic          err_q,     err_d;
    logic          tck_q,     tck_d;
    logic          tms_q,     tms_d;
    logic          tdi_q,     tdi_d;
    logic          trst_n_q,  trst_n_d;

    logic [5:0]    len_clip;
    logic [4:0]    idx_nxt;
    logic          last_bit;

    assign len_clip = (bus.cmd_len_i > 6'd32) ? 6'd32 : bus.cmd_len_i;
    assign idx_nxt  = idx_q + 5'd1;
    assign last_bit = ({1'b0, idx_q} == (len_q - 6'd1));

    assign bus.cmd_ready_o = (state_q == S_IDLE);
    assign bus.rsp_valid_o = (state_q == S_RESP);
    assign bus.rsp_tdo_o   = tdo_q;
    assign bus.rsp_err_o   = err_q;
    assign busy_o          = (state_q != S_IDLE);
    assign jtag_tck_o      = tck_q;
    assign jtag_tms_o      = tms_q;
    assign jtag_tdi_o      = tdi_q;
    assign jtag_trst_n_o   = trst_n_q;

    // Next-state and registered pin values; pins change only on state edges so TCK never glitches.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        tc_d      = tc_q;
        idx_d     = idx_q;
        len_d     = len_q;
        tms_vec_d = tms_vec_q;
        tdi_vec_d = tdi_vec_q;
        tdo_d     = tdo_q;
        err_d     = err_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        trst_n_d  = trst_n_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    len_d     = len_clip;
                    tms_vec_d = bus.cmd_tms_i;
                    tdi_vec_d = bus.cmd_tdi_i;
                    idx_d     = 5'd0;
                    tdo_d     = 32'd0;
                    err_d     = 1'b0;
                    ph_d      = '0;
                    tc_d      = '0;
                    unique case (bus.cmd_op_i)
                        OP_BITS: begin
                            if (len_clip != 6'd0) begin
                                state_d = S_LO;
                                tms_d   = bus.cmd_tms_i[0];
                                tdi_d   = bus.cmd_tdi_i[0];
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                        OP_TRST: begin
                            state_d  = S_TRST;
                            trst_n_d = 1'b0;
                            tck_d    = 1'b0;
                            tms_d    = 1'b1;
                        end
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_LO: begin
                if (ph_q == PH_LAST) begin
                    ph_d         = '0;
                    tdo_d[idx_q] = jtag_tdo_i;
                    tck_d        = 1'b1;
                    state_d      = S_HI;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_HI: begin
                if (ph_q == PH_LAST) begin
                    ph_d  = '0;
                    tck_d = 1'b0;
                    if (last_bit) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_nxt;
                        tms_d   = tms_vec_q[idx_nxt];
                        tdi_d   = tdi_vec_q[idx_nxt];
                        state_d = S_LO;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_TRST: begin
                if (tc_q == TC_LAST) begin
                    trst_n_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tc_d = tc_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and pin registers; reset drops any in-flight command.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            tc_q      <= '0;
            idx_q     <= 5'd0;
            len_q     <= 6'd0;
            tms_vec_q <= 32'd0;
            tdi_vec_q <= 32'd0;
            tdo_q     <= 32'd0;
            err_q     <= 1'b0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            trst_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            tc_q      <= tc_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            tms_vec_q <= tms_vec_d;
            tdi_vec_q <= tdi_vec_d;
            tdo_q     <= tdo_d;
            err_q     <= err_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            trst_n_q  <= trst_n_d;
        end
    end

endmodule

// File: tb/tb_jtag_bitbang_seq.sv
// Directed bench for jtag_bitbang_seq with TCK_DIV=2, TRST_TCKS=8.
// Latencies are counted in clk edges after the accepting edge E0.
module tb_jtag_bitbang_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jtag_bitbang_seq_if bus();

    logic tck, tms, tdi, trst_n, busy;
    logic tdo_drv = 1'b0;
    logic loopb   = 1'b0;
    logic tdo;
    assign tdo = loopb ? tdi : tdo_drv;

    jtag_bitbang_seq #(
        .TCK_DIV   (2),
        .TRST_TCKS (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .busy_o        (busy),
        .jtag_tck_o    (tck),
        .jtag_tms_o    (tms),
        .jtag_tdi_o    (tdi),
        .jtag_trst_n_o (trst_n),
        .jtag_tdo_i    (tdo)
    );

    int checks = 0;
    int errors = 0;

    int          lat;
    int          rises;
    int          hi_cyc;
    int          tms_lo;
    int          trst_lo;
    logic [31:0] r_tdo;
    logic        r_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one command, watch pins until rsp_valid, optionally consume.
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len,
                           input logic [31:0] vtms, input logic [31:0] vtdi,
                           input bit consume);
        int  n;
        logic ptck;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_len_i   = len;
        bus.cmd_tms_i   = vtms;
        bus.cmd_tdi_i   = vtdi;
        bus.rsp_ready_i = consume;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
        n = 0; rises = 0; hi_cyc = 0; tms_lo = 0; trst_lo = 0; ptck = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (tck && !ptck) rises++;
            if (tck) hi_cyc++;
            if (!tms) tms_lo++;
            if (!trst_n) trst_lo++;
            ptck = tck;
            if (bus.rsp_valid_o) break;
        end
        lat   = n - 1;
        r_tdo = bus.rsp_tdo_o;
        r_err = bus.rsp_err_o;
        check("rsp_seen", {31'd0, bus.rsp_valid_o}, 32'd1);
        if (consume) begin
            @(negedge clk);
            check("rsp_drop", {31'd0, bus.rsp_valid_o}, 32'd0);
            check("idle_rdy", {31'd0, bus.cmd_ready_o}, 32'd1);
        end
    endtask

    initial begin
        int held;
        int bad;
        int n;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 2'd0;
        bus.cmd_len_i   = 6'd0;
        bus.cmd_tms_i   = 32'd0;
        bus.cmd_tdi_i   = 32'd0;
        bus.rsp_ready_i = 1'b1;

        // 1: reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tck", {31'd0, tck}, 32'd0);
        check("rst_tms", {31'd0, tms}, 32'd1);
        check("rst_tdi", {31'd0, tdi}, 32'd0);
        check("rst_trst", {31'd0, trst_n}, 32'd1);
        check("rst_rdy", {31'd0, bus.cmd_ready_o}, 32'd1);
        check("rst_rspv", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tdo", bus.rsp_tdo_o, 32'd0);

        // 2: five bits, TMS all ones
        run_cmd(2'd0, 6'd5, 32'h1F, 32'h0, 1'b1);
        check("b5_lat", lat, 21);
        check("b5_rise", rises, 5);
        check("b5_hi", hi_cyc, 10);
        check("b5_tmslo", tms_lo, 0);
        check("b5_tdo", r_tdo, 32'd0);
        check("b5_err", {31'd0, r_err}, 32'd0);

        // 3: loopback captures
        loopb = 1'b1;
        run_cmd(2'd0, 6'd8, 32'h0, 32'hA5, 1'b1);
        check("b8_lat", lat, 33);
        check("b8_rise", rises, 8);
        check("b8_tdo", r_tdo, 32'h0000_00A5);
        check("b8_err", {31'd0, r_err}, 32'd0);
        check("b8_tdi_keep", {31'd0, tdi}, 32'd1);
        check("b8_tms_keep", {31'd0, tms}, 32'd0);
        check("b8_tck_idle", {31'd0, tck}, 32'd0);

        run_cmd(2'd0, 6'd4, 32'hA, 32'hFF, 1'b1);
        check("b4_tdo", r_tdo, 32'h0000_000F);
        check("b4_lat", lat, 17);
        check("b4_tms_keep", {31'd0, tms}, 32'd1);

        run_cmd(2'd0, 6'd40, 32'h0, 32'hDEAD_BEEF, 1'b1);
        check("b40_rise", rises, 32);
        check("b40_lat", lat, 129);
        check("b40_tdo", r_tdo, 32'hDEAD_BEEF);
        check("b40_tms", {31'd0, tms}, 32'd0);
        loopb = 1'b0;

        // 4: zero length and reserved op
        run_cmd(2'd0, 6'd0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        check("b0_lat", lat, 1);
        check("b0_rise", rises, 0);
        check("b0_tdo", r_tdo, 32'd0);
        check("b0_tdi", {31'd0, tdi}, 32'd1);

        run_cmd(2'd2, 6'd8, 32'hFFFF_FFFF, 32'h0, 1'b1);
        check("op2_lat", lat, 1);
        check("op2_err", {31'd0, r_err}, 32'd1);
        check("op2_rise", rises, 0);
        check("op2_tms", {31'd0, tms}, 32'd0);
        check("op2_tdi", {31'd0, tdi}, 32'd1);
        check("op2_trst", trst_lo, 0);

        // 5: TRST with stalled response and a waiting command
        run_cmd(2'd1, 6'd0, 32'h0, 32'h0, 1'b0);
        check("trst_lat", lat, 33);
        check("trst_low", trst_lo, 32);
        check("trst_tms", tms_lo, 0);
        check("trst_rise", rises, 0);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 2'd0;
        bus.cmd_len_i   = 6'd1;
        held = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.cmd_ready_o && bus.rsp_valid_o && !bus.rsp_err_o &&
                bus.rsp_tdo_o == 32'd0 && trst_n && !tck)
                held++;
        end
        check("trst_hold", held, 10);
        bus.cmd_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        check("trst_cons", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("trst_rdy", {31'd0, bus.cmd_ready_o}, 32'd1);

        // 6: reset in the middle of a 32-bit shift
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 2'd0;
        bus.cmd_len_i   = 6'd32;
        bus.cmd_tms_i   = 32'h0;
        bus.cmd_tdi_i   = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
        rises = 0;
        n = 0;
        begin
            logic ptck;
            ptck = 1'b0;
            while (rises < 4 && n < 200) begin
                @(negedge clk);
                n++;
                if (tck && !ptck) rises++;
                ptck = tck;
            end
        end
        check("mid_rises", rises, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_tck", {31'd0, tck}, 32'd0);
        check("mid_tms", {31'd0, tms}, 32'd1);
        check("mid_tdi", {31'd0, tdi}, 32'd0);
        check("mid_trst", {31'd0, trst_n}, 32'd1);
        check("mid_rdy", {31'd0, bus.cmd_ready_o}, 32'd1);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_tdo", bus.rsp_tdo_o, 32'd0);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o || tck) bad++;
        end
        check("mid_norsp", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
